// File: rtl/sdr_read_capture.sv
`default_nettype none
// sdr_read_capture: SDRAM read return path (CAS-latency command tracking, beat capture, FWFT read FIFO).
// Defining SDR_READ_CAPTURE_RLAST_EN adds the RLAST output and stores a last-beat bit with every FIFO entry.
module sdr_read_capture #(
  parameter int DSIZE      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CL_MAX     = 3
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          RD_CMD,
  input  logic [1:0]                    RD_BL,
  input  logic [1:0]                    CAS_LAT,
  input  logic [DSIZE-1:0]              DQIN,
  input  logic                          OVF_CLR,
  output logic [DSIZE-1:0]              RDATA,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          BUSY,
  output logic                          OVERFLOW
`ifdef SDR_READ_CAPTURE_RLAST_EN
  ,
  output logic                          RLAST
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SDR_READ_CAPTURE_RLAST_EN
  localparam int EW = DSIZE + 1;
`else
  localparam int EW = DSIZE;
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // ---------------- command tracking pipeline ----------------
  logic [CL_MAX-1:0] pipe_vld;
  logic [1:0]        pipe_bl [CL_MAX];
  int                cl;
  logic              emerge;
  logic [1:0]        emerge_bl;
  logic              busy_pipe;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pipe_vld <= '0;
      for (int i = 0; i < CL_MAX; i++) begin
        pipe_bl[i] <= 2'd0;
      end
    end else begin
      pipe_vld <= {pipe_vld[CL_MAX-2:0], RD_CMD};
      pipe_bl[0] <= RD_BL;
      for (int i = 1; i < CL_MAX; i++) begin
        pipe_bl[i] <= pipe_bl[i-1];
      end
    end
  end

  // Entry sampled at edge T sits in stage cl-1 just before edge T+cl.
  always_comb begin
    cl        = (CAS_LAT == 2'd3 && CL_MAX >= 3) ? 3 : 2;
    emerge    = 1'b0;
    emerge_bl = 2'd0;
    busy_pipe = 1'b0;
    for (int i = 0; i < CL_MAX; i++) begin
      if (i < cl) begin
        busy_pipe = busy_pipe | pipe_vld[i];
      end
      if (i == cl - 1) begin
        emerge    = pipe_vld[i];
        emerge_bl = pipe_bl[i];
      end
    end
  end

  // ---------------- burst counter FSM ----------------
  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;   // beats still to sample after the current one
  logic       sample;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sample    = 1'b0;
    if (emerge) begin
      // A new burst always wins, truncating any burst in progress.
      sample    = 1'b1;
      cnt_nxt   = (3'd1 << emerge_bl) - 3'd1;
      state_nxt = (cnt_nxt == 3'd0) ? IDLE : BURST;
    end else if (state == BURST) begin
      sample    = 1'b1;
      cnt_nxt   = cnt - 3'd1;
      state_nxt = (cnt_nxt == 3'd0) ? IDLE : BURST;
    end
  end

  // ---------------- capture register ----------------
  logic             cap_vld;
  logic [DSIZE-1:0] cap_data;
  logic [EW-1:0]    push_word;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cap_vld  <= 1'b0;
      cap_data <= '0;
    end else begin
      cap_vld <= sample;
      if (sample) begin
        cap_data <= DQIN;
      end
    end
  end

`ifdef SDR_READ_CAPTURE_RLAST_EN
  logic cap_last;
  logic sample_last;

  assign sample_last = (cnt_nxt == 3'd0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cap_last <= 1'b0;
    end else if (sample) begin
      cap_last <= sample_last;
    end
  end

  // A reload arriving as the capture register is pushed marks that word as the last one kept.
  assign push_word = {cap_last | emerge, cap_data};
`else
  assign push_word = cap_data;
`endif

  // ---------------- FWFT FIFO ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push, drop;
  logic [EW-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = !empty && RREADY;
  assign push  = cap_vld && (!full || pop);
  assign drop  = cap_vld && full && !pop;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_word;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        OVERFLOW <= 1'b1;
      end else if (OVF_CLR) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign RVALID     = !empty;
  assign RDATA      = empty ? '0 : head[DSIZE-1:0];
  assign FIFO_LEVEL = wr_ptr - rd_ptr;
  assign BUSY       = busy_pipe || (state == BURST) || cap_vld;

`ifdef SDR_READ_CAPTURE_RLAST_EN
  assign RLAST = !empty && head[DSIZE];
`endif

endmodule
`default_nettype wire

// File: doc/sdr_read_capture.md
Name: sdr_read_capture

Overview:
- SDRAM read-data return path.
- Tracks issued READ commands through the CAS-latency window and samples DQ for each burst beat.
- Buffers captured words in a small first-word-fall-through (FWFT) FIFO.
- Presents words to the host on a valid/ready interface. The SDRAM cannot be stalled, so words that cannot be stored are dropped and flagged.

Parameters:
- DSIZE, 32, data width in bits.
- FIFO_DEPTH, 8, read FIFO entries; power of 2, at least 4.
- CL_MAX, 3, deepest supported CAS latency; sets the command-tracking pipeline length.

Ports:
- CLK  in  1  system clock; same clock as the SDRAM command path.
- RESET_N  in  1  reset, asynchronous, active-low.
- RD_CMD  in  1  one-cycle pulse: a READ command is driven to the SDRAM this cycle.
- RD_BL  in  2  burst length of this READ: 0=1, 1=2, 2=4, 3=8 beats. Sampled with RD_CMD.
- CAS_LAT  in  2  CAS latency, 2 or 3. Must be static while BUSY. Values 0 and 1 are treated as 2.
- DQIN  in  DSIZE  SDRAM DQ input.
- OVF_CLR  in  1  clears OVERFLOW.
- RDATA  out  DSIZE  FIFO head word.
- RVALID  out  1  FIFO non-empty.
- RREADY  in  1  host accepts the head word.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- BUSY  out  1  at least one burst is still outstanding.
- OVERFLOW  out  1  sticky flag: a captured word was dropped.

Behaviour:
- Reset values: RDATA=0, RVALID=0, FIFO_LEVEL=0, BUSY=0, OVERFLOW=0. The tracking pipeline, burst counter and FIFO pointers are all cleared.
- Reset asserted mid-burst: all in-flight beats and all FIFO contents are discarded.
- Command tracking:
  - RD_CMD sampled at edge T pushes {valid, RD_BL} into a shift pipeline CL_MAX deep.
  - The entry emerges after CAS_LAT edges.
- Burst counter FSM, states IDLE and BURST:
  - An emerging entry at edge T+CAS_LAT loads a beat count of 2^RD_BL and enters BURST.
  - In BURST, DQIN is sampled into a capture register at edges T+CAS_LAT+k, for k=0..2^RD_BL-1.
  - When the count reaches 0, the FSM returns to IDLE, unless a new entry emerges at that same edge, in which case it stays in BURST with the new count.
- Truncation:
  - A new entry emerging while in BURST reloads the counter; the remaining beats of the old burst are never sampled.
  - This matches SDRAM READ-interrupts-READ semantics.
- Push and latency:
  - The capture register is pushed into the FIFO one edge after sampling, at edge T+CAS_LAT+k+1.
  - Latency from the RD_CMD edge to RVALID is CAS_LAT+1 cycles when the FIFO is empty.
- FIFO:
  - FWFT: RDATA is valid whenever RVALID=1.
  - A pop occurs on an edge where RVALID && RREADY.
  - RREADY while empty is ignored.
- Full boundary:
  - Push while FIFO full with no pop: the word is dropped and OVERFLOW is set.
  - Push and pop in the same cycle while full: the push is accepted, no overflow, level unchanged.
  - Push and pop in the same cycle at level 1: RDATA advances to the new word and RVALID stays 1.
- OVERFLOW:
  - Cleared by OVF_CLR.
  - If OVF_CLR and a new drop occur in the same cycle, the set wins.
- Pointers are $clog2(FIFO_DEPTH) bits plus a wrap bit. Full is when the index bits are equal and the wrap bits differ.
- BUSY is high from the edge after RD_CMD is sampled until the edge of the final push of the last outstanding burst.

Optional Feature:
- Macro: SDR_READ_CAPTURE_RLAST_EN.
- When defined:
  - Adds output RLAST (1 bit). It is stored in the FIFO alongside each word, so each FIFO entry is DSIZE+1 bits.
  - RLAST=1 on the final beat of each burst.
  - For a truncated burst, RLAST=1 on the last beat actually retained. The one-cycle push lag lets the truncating reload mark the capture register before it is pushed.
  - RLAST reset value is 0, and it is qualified by RVALID.
- When undefined:
  - The RLAST port does not exist and FIFO entries are DSIZE bits.
  - All other behaviour is identical.

Test Plan:
- Single burst:
  - Stimulus: CAS_LAT=2, RD_CMD at edge 10 with RD_BL=2, DQIN = 0xA0..0xA3 at edges 12..15, RREADY=1.
  - Required: RVALID from edge 13 to 16, RDATA = 0xA0, 0xA1, 0xA2, 0xA3; BUSY falls at edge 16.
- CAS latency 3:
  - Stimulus: same as above with CAS_LAT=3, DQIN shifted to edges 13..16.
  - Required: first RVALID at edge 14; all words match.
- Truncation:
  - Stimulus: CAS_LAT=2, RD_BL=3 at edge 0, second RD_CMD with RD_BL=0 at edge 2.
  - Required: only old beats sampled at edges 2..3 plus one new beat at edge 4 are delivered (3 words). With RLAST_EN, RLAST=1 on word 2 and on word 3.
- Overflow:
  - Stimulus: FIFO_DEPTH=8, RREADY=0, two back-to-back BL=8 bursts.
  - Required: FIFO_LEVEL saturates at 8, OVERFLOW=1, and the first 8 words are intact when drained.
  - Then: OVF_CLR pulse → OVERFLOW=0.
- Full with simultaneous push and pop:
  - Stimulus: FIFO at 8, RREADY=1 during an incoming burst.
  - Required: no OVERFLOW, level stays 8, order preserved.
- Reset mid-burst:
  - Stimulus: assert RESET_N=0 during beat 3 of a BL=8 burst, release, then issue a BL=1 read.
  - Required: all outputs 0 immediately on assertion; after release only the new single word appears.
